// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states and frame constants.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_MIN_DIV    = 2;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is refused even if a pop coincides.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO-fed serialiser with a latched per-frame bit period
// and a one-cycle pulse once the line has fully drained.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DIV_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DIV_WIDTH-1:0]     cfg_divider,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     ser_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     irq_drained
);

    tx_state_e            state;
    tx_state_e            state_next;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shifter;
    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 start_frame;
    logic                 irq_set;
    logic                 avail_q;
    logic                 bit_end;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_valid),
        .wdata  (tx_data),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    assign div_eff  = (cfg_divider < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : cfg_divider;
    assign bit_end  = (cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IDLE waits on the registered availability flag, giving the two-edge enqueue-to-start latency.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        irq_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (avail_q && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    start_frame = 1'b1;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == 3'(UART_DATA_BITS - 1))) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        start_frame = 1'b1;
                        state_next  = ST_START;
                    end else begin
                        irq_set    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ser_tx      <= 1'b1;
            irq_drained <= 1'b0;
            avail_q     <= 1'b0;
            div_q       <= DIV_WIDTH'(UART_MIN_DIV);
            cnt         <= '0;
            bit_idx     <= '0;
            shifter     <= '0;
        end else begin
            irq_drained <= irq_set;
            avail_q     <= !fifo_empty;
            if (start_frame) begin
                div_q   <= div_eff;
                cnt     <= div_eff - DIV_WIDTH'(1);
                shifter <= fifo_rdata;
                bit_idx <= '0;
                ser_tx  <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (bit_end) begin
                    cnt <= div_q - DIV_WIDTH'(1);
                    case (state)
                        ST_START: begin
                            ser_tx  <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                        ST_DATA: begin
                            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                                ser_tx <= 1'b1;
                            end else begin
                                ser_tx  <= shifter[0];
                                shifter <= shifter >> 1;
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                        default: ser_tx <= 1'b1;
                    endcase
                end else begin
                    cnt <= cnt - DIV_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a serial-line monitor decodes frames and compares.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int DEPTH     = 8;
    localparam int DIV_WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [DIV_WIDTH-1:0]   cfg_divider = 32'd4;
    logic [7:0]             tx_data = 8'h00;
    logic                   tx_valid = 1'b0;
    logic                   tx_ready;
    logic                   ser_tx;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   irq_drained;

    int          errors = 0;
    int          checks = 0;
    byte unsigned exp_q[$];
    logic [DIV_WIDTH-1:0] cfg_at_edge;

    bit          in_frame = 0;
    bit          end_pending = 0;
    int          idx;
    int          mdiv;
    logic [9:0]  bits;
    bit          unstable;
    int          stray_irq = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_divider (cfg_divider),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ser_tx      (ser_tx),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .irq_drained (irq_drained)
    );

    always #5 clk = ~clk;

    // Divider value the DUT sees at each edge, for the monitor's per-frame bit period.
    always @(posedge clk) cfg_at_edge <= cfg_divider;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input byte unsigned b, input bit expect_accept);
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        check_output("tx_ready", tx_ready, expect_accept);
        @(posedge clk);
        if (expect_accept) exp_q.push_back(b);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || end_pending) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_timeout", int'(n >= max_cycles), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic begin_frame();
        in_frame = 1;
        mdiv     = (cfg_at_edge < 2) ? 2 : int'(cfg_at_edge);
        bits     = '0;
        bits[0]  = ser_tx;
        idx      = 1;
        unstable = 0;
    endtask

    // Line monitor: a frame is 10 bits of mdiv cycles each; every sample in a bit must agree.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_frame    = 0;
                end_pending = 0;
            end else if (end_pending) begin
                end_pending = 0;
                check_output("irq_at_frame_end", irq_drained, int'(exp_q.size() == 0));
                check_output("line_after_stop", ser_tx, int'(exp_q.size() == 0));
                if (!ser_tx) begin_frame();
            end else begin
                if (irq_drained) stray_irq++;
                if (in_frame) begin
                    if (idx % mdiv == 0) bits[idx / mdiv] = ser_tx;
                    else if (ser_tx != bits[idx / mdiv]) unstable = 1;
                    idx++;
                    if (idx == UART_FRAME_BITS * mdiv) begin
                        check_output("bit_stability", int'(unstable), 0);
                        check_output("stop_bit", bits[9], 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_frame: got %0h expected no frame", bits[8:1]);
                        end else begin
                            check_output("rx_byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                        end
                        in_frame    = 0;
                        end_pending = 1;
                    end
                end else if (!ser_tx) begin
                    begin_frame();
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte unsigned hello[6];
        int lows;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

        #12;
        check_output("reset_ser_tx", ser_tx, 1);
        check_output("reset_tx_ready", tx_ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_level", fifo_level, 0);
        check_output("reset_irq", irq_drained, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] single byte, latency and frame shape");
        cfg_divider = 32'd4;
        apply_stimulus(8'h55, 1);
        @(negedge clk);
        check_output("latency_n0", ser_tx, 1);
        @(negedge clk);
        check_output("latency_n1", ser_tx, 1);
        @(negedge clk);
        check_output("latency_n2", ser_tx, 0);
        check_output("busy_in_frame", busy, 1);
        wait_drain(200);

        $display("[TB] back-to-back frames");
        apply_stimulus(8'h41, 1);
        apply_stimulus(8'h42, 1);
        wait_drain(300);

        $display("[TB] fill FIFO behind an active frame");
        cfg_divider = 32'd16;
        apply_stimulus(8'h80, 1);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 9; i++) apply_stimulus(8'(8'h10 + i), i < 8);
        @(negedge clk);
        check_output("fifo_level_full", fifo_level, 8);
        check_output("tx_ready_full", tx_ready, 0);
        wait_drain(2000);

        $display("[TB] small dividers and mid-frame divider change");
        cfg_divider = 32'd0;
        apply_stimulus(8'hA5, 1);
        wait_drain(100);
        cfg_divider = 32'd1;
        apply_stimulus(8'h3C, 1);
        wait_drain(100);
        cfg_divider = 32'd4;
        apply_stimulus(8'h0F, 1);
        apply_stimulus(8'hF0, 1);
        repeat (8) @(posedge clk);
        #1;
        cfg_divider = 32'd8;
        wait_drain(400);

        $display("[TB] reset during data bit 3");
        cfg_divider = 32'd4;
        apply_stimulus(8'hC3, 1);
        repeat (19) @(posedge clk);
        #1;
        check_output("pre_reset_bit3", ser_tx, 0);
        #1;
        resetn = 1'b0;
        #1;
        check_output("async_reset_ser_tx", ser_tx, 1);
        check_output("async_reset_busy", busy, 0);
        check_output("async_reset_level", fifo_level, 0);
        check_output("async_reset_ready", tx_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!ser_tx) lows++;
        end
        check_output("post_reset_line_low_cycles", lows, 0);
        check_output("post_reset_busy", busy, 0);

        $display("[TB] Hello message twice at divider 106");
        cfg_divider = 32'd106;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 6; i++) apply_stimulus(hello[i], 1);
            wait_drain(8000);
            lows = 0;
            repeat (20) begin
                @(negedge clk);
                if (!ser_tx) lows++;
            end
            check_output("gap_line_low_cycles", lows, 0);
        end

        $display("[TB] randomized bursts");
        for (int r = 0; r < 8; r++) begin
            int n;
            cfg_divider = 32'($urandom_range(0, 9));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) apply_stimulus(8'($urandom), 1);
            wait_drain(1000);
        end

        check_output("stray_irq", stray_irq, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
